// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data memory responder.
package dmem_pkg;

  localparam int LATENCY_DEF = 4;
  localparam int DEPTH_DEF   = 256;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

endpackage

// File: rtl/dmem_if.sv
// MEM-stage request/response bundle; master is the pipeline, slave is the responder.
interface dmem_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        ack_o;
  logic        err_o;

  modport master (
    output MemRead_i, MemWrite_i, addr_i, wdata_i, be_i,
    input  rdata_o, stall_o, ack_o, err_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, wdata_i, be_i,
    output rdata_o, stall_o, ack_o, err_o
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word storage built from four byte lanes; synchronous byte-enabled write.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_q [DEPTH];

      always_ff @(posedge clk_i) begin
        if (we_i && be_i[gi]) begin
          lane_q[idx_i] <= wdata_i[8*gi +: 8];
        end
      end

      // Read is combinational here; the responder owns the output register.
      assign rdata_o[8*gi +: 8] = lane_q[idx_i];
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data memory for the MEM stage: stalls the pipeline for LATENCY+1
// cycles per access, then pulses ack (and err for misaligned addresses) for one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  req_t             req_q;
  logic [31:0]      rdata_q;
  logic             ack_q;
  logic             err_q;

  logic        request;
  logic        misaligned;
  logic        access_now;
  logic        arr_we;
  logic [31:0] arr_rdata;
  logic        unused_addr_bits;

  assign request    = bus.MemRead_i | bus.MemWrite_i;
  assign misaligned = |req_q.addr[1:0];
  assign access_now = (state_q == WAIT) && (cnt_q == '0);
  assign arr_we     = access_now && req_q.write && !misaligned;

  // Addresses wrap modulo the array size; bits above the word index are don't-care.
  assign unused_addr_bits = ^req_q.addr[31:AW+2];

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .be_i    (req_q.be),
    .idx_i   (req_q.addr[AW+1:2]),
    .wdata_i (req_q.wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (request) begin
            state_q <= WAIT;
            cnt_q   <= CNT_LOAD;
            req_q   <= '{write: bus.MemWrite_i,
                         addr:  bus.addr_i,
                         wdata: bus.wdata_i,
                         be:    bus.be_i};
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            ack_q   <= 1'b1;
            err_q   <= misaligned;
            if (!req_q.write) begin
              rdata_q <= misaligned ? 32'h0 : arr_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        // The request still visible here is the one just completed.
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall_o = ((state_q == IDLE) && request) || (state_q == WAIT);
  assign bus.rdata_o = rdata_q;
  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, reset corner case and
// randomized accesses against a word-array reference model.
module tb_dmem_responder;

  localparam int LAT = 4;
  localparam int DEP = 256;

  logic clk;
  logic rst_n;

  dmem_if bus ();

  dmem_responder #(
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] model_mem [DEP];
  logic [31:0] model_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: whole-word arithmetic on the model array.
  task automatic ref_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            output logic exp_err, output logic [31:0] exp_rdata);
    int idx;
    idx     = int'((a / 4) % DEP);
    exp_err = (a % 4) != 0;
    if (wr) begin
      if (!exp_err) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end else if (rd) begin
      model_rdata = exp_err ? 32'h0 : model_mem[idx];
    end
    exp_rdata = model_rdata;
  endtask

  // Starts just after a negedge with the DUT idle; ends the same way.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int stalls, output logic ack, output logic err,
                        output logic [31:0] rdata);
    bus.MemRead_i  = rd;
    bus.MemWrite_i = wr;
    bus.addr_i     = a;
    bus.wdata_i    = wd;
    bus.be_i       = be;
    #1;
    stalls = 0;
    while (bus.stall_o && stalls < 40) begin
      stalls++;
      @(negedge clk); #1;
    end
    ack   = bus.ack_o;
    err   = bus.err_o;
    rdata = bus.rdata_o;
    // Request stays up through RESP, as the pipeline would hold it.
    @(posedge clk); #1;
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
    @(negedge clk); #1;
    check32("no_reaccept_stall", 32'(bus.stall_o), 32'd0);
    check32("ack_single_pulse", 32'(bus.ack_o), 32'd0);
  endtask

  task automatic run(input string name, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input logic use_tbl, input logic tbl_err, input logic tbl_chk,
                     input logic [31:0] tbl_rdata);
    int          stalls;
    logic        ack, err, m_err;
    logic [31:0] rdata, m_rdata;
    ref_access(rd, wr, a, wd, be, m_err, m_rdata);
    access(rd, wr, a, wd, be, stalls, ack, err, rdata);
    check32({name, "_stalls"}, 32'(stalls), 32'(LAT + 1));
    check32({name, "_ack"}, 32'(ack), 32'd1);
    if (use_tbl) begin
      check32({name, "_err"}, 32'(err), 32'(tbl_err));
      if (tbl_chk) check32({name, "_rdata"}, rdata, tbl_rdata);
    end else begin
      check32({name, "_err"}, 32'(err), 32'(m_err));
      check32({name, "_rdata"}, rdata, m_rdata);
    end
    $display("%s rd=%0d wr=%0d addr=%h wdata=%h be=%b -> stalls=%0d ack=%0d err=%0d rdata=%h",
             name, rd, wr, a, wd, be, stalls, ack, err, rdata);
  endtask

  vec_t tbl [$];

  initial begin
    logic        seen_ack;
    logic        rd, wr;
    logic [31:0] a;

    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
    bus.addr_i     = '0;
    bus.wdata_i    = '0;
    bus.be_i       = '0;
    rst_n          = 1'b0;
    model_rdata    = '0;

    repeat (2) @(negedge clk);
    #1;
    check32("reset_rdata", bus.rdata_o, 32'h0);
    check32("reset_ack", 32'(bus.ack_o), 32'd0);
    check32("reset_err", 32'(bus.err_o), 32'd0);
    check32("reset_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Fill the array so every later read has a defined expectation.
    for (int i = 0; i < DEP; i++) begin
      run("init", 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    end

    //            rd    wr    addr          wdata         be     err   chk   rdata
    tbl.push_back('{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF,  1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        4'h0,  1'b0, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 1'b1, 32'h20,       32'hFFFFFFFF, 4'hF,  1'b0, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 1'b1, 32'h20,       32'h11223344, 4'b0101, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h20,       32'h0,        4'h0,  1'b0, 1'b1, 32'hFF22FF44});
    tbl.push_back('{1'b0, 1'b1, 32'h23,       32'h00000000, 4'hF,  1'b1, 1'b1, 32'hFF22FF44});
    tbl.push_back('{1'b1, 1'b0, 32'h20,       32'h0,        4'h0,  1'b0, 1'b1, 32'hFF22FF44});
    tbl.push_back('{1'b0, 1'b1, 32'h40,       32'h9,        4'hF,  1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h40,       32'h0,        4'h0,  1'b0, 1'b1, 32'h9});
    tbl.push_back('{1'b0, 1'b1, 32'h40 + 4*DEP, 32'h5,      4'hF,  1'b0, 1'b1, 32'h9});
    tbl.push_back('{1'b1, 1'b0, 32'h40,       32'h0,        4'h0,  1'b0, 1'b1, 32'h5});
    tbl.push_back('{1'b1, 1'b1, 32'h50,       32'h7,        4'hF,  1'b0, 1'b1, 32'h5});
    tbl.push_back('{1'b1, 1'b0, 32'h50,       32'h0,        4'h0,  1'b0, 1'b1, 32'h7});
    tbl.push_back('{1'b0, 1'b1, 32'h50,       32'hAAAAAAAA, 4'h0,  1'b0, 1'b1, 32'h7});
    tbl.push_back('{1'b1, 1'b0, 32'h50,       32'h0,        4'h0,  1'b0, 1'b1, 32'h7});
    tbl.push_back('{1'b1, 1'b0, 32'h51,       32'h0,        4'h0,  1'b1, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 32'h30,       32'h1,        4'hF,  1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 32'h30,       32'h0,        4'h0,  1'b0, 1'b1, 32'h1});

    foreach (tbl[i]) begin
      run($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
          tbl[i].be, 1'b1, tbl[i].exp_err, tbl[i].chk_rd, tbl[i].exp_rdata);
    end

    // Reset during the second WAIT cycle of a write must abort it.
    bus.MemWrite_i = 1'b1;
    bus.addr_i     = 32'h30;
    bus.wdata_i    = 32'hCAFEF00D;
    bus.be_i       = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check32("midrst_stall_before", 32'(bus.stall_o), 32'd1);
    rst_n          = 1'b0;
    bus.MemWrite_i = 1'b0;
    #1;
    check32("midrst_rdata", bus.rdata_o, 32'h0);
    check32("midrst_ack", 32'(bus.ack_o), 32'd0);
    check32("midrst_stall", 32'(bus.stall_o), 32'd0);
    seen_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack_o) seen_ack = 1'b1;
    end
    check32("midrst_no_ack", 32'(seen_ack), 32'd0);
    rst_n       = 1'b1;
    model_rdata = 32'h0;
    #1;
    $display("midrst write 0x30 aborted by reset");
    run("midrst_readback", 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h1);

    for (int i = 0; i < 150; i++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      run($sformatf("rnd%0d", i), rd, wr, a, $urandom, 4'($urandom), 1'b0, 1'b0, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
